mem_arbiter: RTL and testbench

- Shares the single unified memory port between the Icache subsystem (Icache_ctrl and prefetch, already muxed inside Icache) and the Dcache.
- Picks one requester per cycle and forwards its command, address and store data to memory.
- Returns the memory's accept response only to the granted requester.
- Keeps a 15-entry tag-ownership table so each load completion (mem2proc_tag) goes only to the cache that issued it.
- Sits between Icache/Dcache and the memory model at processor top level.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between Icache and Dcache, with a
//            tag-ownership table that routes each load completion back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       Icache2mem_command_i,
    input  logic [63:0]      Icache2mem_addr_i,
    input  logic [1:0]       Dcache2mem_command_i,
    input  logic [63:0]      Dcache2mem_addr_i,
    input  logic [63:0]      Dcache2mem_data_i,
    input  logic [TAG_W-1:0] mem2proc_response_i,
    input  logic [63:0]      mem2proc_data_i,
    input  logic [TAG_W-1:0] mem2proc_tag_i,
    output logic [1:0]       proc2mem_command_o,
    output logic [63:0]      proc2mem_addr_o,
    output logic [63:0]      proc2mem_data_o,
    output logic [TAG_W-1:0] mem2Icache_response_o,
    output logic [TAG_W-1:0] mem2Icache_tag_o,
    output logic [63:0]      mem2Icache_data_o,
    output logic [TAG_W-1:0] mem2Dcache_response_o,
    output logic [TAG_W-1:0] mem2Dcache_tag_o,
    output logic [63:0]      mem2Dcache_data_o,
    output logic             arb_err_o
);

    localparam int         c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam int         c_DEPTH      = 2 ** TAG_W;
    localparam logic [1:0] c_CMD_NONE   = 2'd0;
    localparam logic [1:0] c_CMD_LOAD   = 2'd1;
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);

    // Entry 0 stands for "no tag" and is never allocated, so it stays invalid.
    logic [c_DEPTH-1:0] r_valid;
    logic [c_DEPTH-1:0] r_owner;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_err;

    logic       w_i_req;
    logic       w_d_req;
    logic       w_grant_i;
    logic       w_grant_d;
    logic [1:0] w_cmd;
    logic       w_alloc;
    logic       w_retire;
    logic       w_cpl_hit;
    logic       w_cpl_orphan;
    logic       w_alloc_clash;

    assign w_i_req   = (Icache2mem_command_i != c_CMD_NONE);
    assign w_d_req   = (Dcache2mem_command_i != c_CMD_NONE);
    assign w_grant_i = w_i_req && (!w_d_req || (r_starve_cnt == c_STARVE_LIM));
    assign w_grant_d = w_d_req && !w_grant_i;

    assign w_cmd = w_grant_i ? Icache2mem_command_i :
                   w_grant_d ? Dcache2mem_command_i : c_CMD_NONE;

    assign w_alloc      = (w_cmd == c_CMD_LOAD) && (mem2proc_response_i != '0);
    assign w_retire     = (mem2proc_tag_i != '0);
    assign w_cpl_hit    = w_retire && r_valid[mem2proc_tag_i];
    assign w_cpl_orphan = w_retire && !r_valid[mem2proc_tag_i];
    // A same-cycle retire of the very tag being reused is a legal recycle.
    assign w_alloc_clash = w_alloc && r_valid[mem2proc_response_i] &&
                           !(w_retire && (mem2proc_tag_i == mem2proc_response_i));

    always_comb begin
        proc2mem_command_o    = c_CMD_NONE;
        proc2mem_addr_o       = '0;
        proc2mem_data_o       = '0;
        mem2Icache_response_o = '0;
        mem2Dcache_response_o = '0;
        mem2Icache_tag_o      = '0;
        mem2Dcache_tag_o      = '0;
        mem2Icache_data_o     = '0;
        mem2Dcache_data_o     = '0;
        if (!rst) begin
            proc2mem_command_o = w_cmd;
            mem2Icache_data_o  = mem2proc_data_i;
            mem2Dcache_data_o  = mem2proc_data_i;
            if (w_grant_i) begin
                proc2mem_addr_o       = Icache2mem_addr_i;
                mem2Icache_response_o = mem2proc_response_i;
            end else if (w_grant_d) begin
                proc2mem_addr_o       = Dcache2mem_addr_i;
                proc2mem_data_o       = Dcache2mem_data_i;
                mem2Dcache_response_o = mem2proc_response_i;
            end
            if (w_cpl_hit) begin
                if (r_owner[mem2proc_tag_i]) begin
                    mem2Dcache_tag_o = mem2proc_tag_i;
                end else begin
                    mem2Icache_tag_o = mem2proc_tag_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_owner      <= '0;
            r_starve_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_retire) begin
                r_valid[mem2proc_tag_i] <= 1'b0;
            end
            // Written after the retire so a recycled tag ends valid.
            if (w_alloc) begin
                r_valid[mem2proc_response_i] <= 1'b1;
                r_owner[mem2proc_response_i] <= w_grant_d;
            end
            if (w_cpl_orphan || w_alloc_clash) begin
                r_err <= 1'b1;
            end
            if (w_i_req && w_grant_d) begin
                if (r_starve_cnt != c_STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign arb_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed vector bench for mem_arbiter (STARVE_MAX=4, TAG_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [1:0] c_N = 2'd0;
    localparam logic [1:0] c_L = 2'd1;
    localparam logic [1:0] c_S = 2'd2;

    typedef struct {
        logic        rst;
        logic [1:0]  icmd;
        logic [63:0] iaddr;
        logic [1:0]  dcmd;
        logic [63:0] daddr;
        logic [63:0] ddata;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] mdata;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_ir;
        logic [3:0]  e_dr;
        logic [3:0]  e_it;
        logic [3:0]  e_dt;
        logic        e_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  icmd;
    logic [63:0] iaddr;
    logic [1:0]  dcmd;
    logic [63:0] daddr;
    logic [63:0] ddata;
    logic [3:0]  resp;
    logic [63:0] mdata;
    logic [3:0]  tag;
    logic [1:0]  p_cmd;
    logic [63:0] p_addr;
    logic [63:0] p_data;
    logic [3:0]  i_resp;
    logic [3:0]  i_tag;
    logic [63:0] i_data;
    logic [3:0]  d_resp;
    logic [3:0]  d_tag;
    logic [63:0] d_data;
    logic        err;

    int   n_vec;
    int   n_miss;
    vec_t tbl[$];

    mem_arbiter #(.STARVE_MAX(4), .TAG_W(4)) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .Icache2mem_command_i  (icmd),
        .Icache2mem_addr_i     (iaddr),
        .Dcache2mem_command_i  (dcmd),
        .Dcache2mem_addr_i     (daddr),
        .Dcache2mem_data_i     (ddata),
        .mem2proc_response_i   (resp),
        .mem2proc_data_i       (mdata),
        .mem2proc_tag_i        (tag),
        .proc2mem_command_o    (p_cmd),
        .proc2mem_addr_o       (p_addr),
        .proc2mem_data_o       (p_data),
        .mem2Icache_response_o (i_resp),
        .mem2Icache_tag_o      (i_tag),
        .mem2Icache_data_o     (i_data),
        .mem2Dcache_response_o (d_resp),
        .mem2Dcache_tag_o      (d_tag),
        .mem2Dcache_data_o     (d_data),
        .arb_err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic [1:0] ic, input logic [63:0] ia,
        input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
        input logic [3:0] rs, input logic [3:0] tg, input logic [63:0] md,
        input logic [1:0] ec, input logic [63:0] ea, input logic [63:0] ed,
        input logic [3:0] eir, input logic [3:0] edr, input logic [3:0] eit,
        input logic [3:0] edt, input logic ee);
        vec_t v;
        v.rst = r; v.icmd = ic; v.iaddr = ia; v.dcmd = dc; v.daddr = da;
        v.ddata = dd; v.resp = rs; v.tag = tg; v.mdata = md;
        v.e_cmd = ec; v.e_addr = ea; v.e_data = ed; v.e_ir = eir;
        v.e_dr = edr; v.e_it = eit; v.e_dt = edt; v.e_err = ee;
        return v;
    endfunction

    // Drive after the falling edge, sample just before the next rising edge.
    task automatic apply(input vec_t v, input string name);
        logic [63:0] e_md;
        @(negedge clk);
        #1;
        rst = v.rst; icmd = v.icmd; iaddr = v.iaddr; dcmd = v.dcmd;
        daddr = v.daddr; ddata = v.ddata; resp = v.resp; tag = v.tag;
        mdata = v.mdata;
        #3;
        e_md = v.rst ? 64'd0 : v.mdata;
        n_vec++;
        if (p_cmd !== v.e_cmd || p_addr !== v.e_addr || p_data !== v.e_data ||
            i_resp !== v.e_ir || d_resp !== v.e_dr || i_tag !== v.e_it ||
            d_tag !== v.e_dt || err !== v.e_err ||
            i_data !== e_md || d_data !== e_md) begin
            n_miss++;
            $display("FAIL %s vec%0d got cmd=%0d addr=%h data=%h ir=%0d dr=%0d it=%0d dt=%0d err=%0d idat=%h ddat=%h | need cmd=%0d addr=%h data=%h ir=%0d dr=%0d it=%0d dt=%0d err=%0d dat=%h",
                     name, n_vec, p_cmd, p_addr, p_data, i_resp, d_resp, i_tag, d_tag,
                     err, i_data, d_data, v.e_cmd, v.e_addr, v.e_data, v.e_ir,
                     v.e_dr, v.e_it, v.e_dt, v.e_err, e_md);
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1; icmd = c_N; iaddr = '0; dcmd = c_N; daddr = '0; ddata = '0;
        resp = '0; tag = '0; mdata = '0;
        repeat (2) @(posedge clk);

        // Reset with live inputs, then Icache load/complete, Dcache store, orphan tag
        tbl.push_back(mk(1, c_L, 64'h100, c_L, 64'h300, 64'h77, 3, 3, 64'hAA,  c_N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 0, 0,                         c_N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_L, 64'h100, c_N, 0, 0, 3, 0, 0,                   c_L, 64'h100, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 3, 64'hDEAD,                  c_N, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_S, 64'h200, 64'h55, 7, 0, 0,              c_S, 64'h200, 64'h55, 0, 7, 0, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 7, 64'h7,                     c_N, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 0, 0,                         c_N, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, c_N, 0, c_N, 0, 0, 0, 0, 0,                         c_N, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, c_N, 0, c_N, 0, 0, 0, 0, 0,                         c_N, 0, 0, 0, 0, 0, 0, 0));
        // Tag 5 retired from Icache and reallocated to Dcache in one cycle
        tbl.push_back(mk(0, c_L, 64'h140, c_N, 0, 0, 5, 0, 0,                   c_L, 64'h140, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_L, 64'h240, 0, 5, 5, 64'h11,              c_L, 64'h240, 0, 0, 5, 5, 0, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 5, 64'h22,                    c_N, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(mk(0, c_N, 0, c_N, 0, 0, 0, 0, 0,                         c_N, 0, 0, 0, 0, 0, 0, 0));
        // Rejected conflicts still advance the starvation count
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, c_L, 64'h180, c_L, 64'h280, 0, 0, 0, 0,         c_L, 64'h280, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, c_L, 64'h180, c_L, 64'h280, 0, 0, 0, 0,             c_L, 64'h180, 0, 0, 0, 0, 0, 0));
        foreach (tbl[k]) apply(tbl[k], "table");

        // Continuous conflict, memory always accepts: D,D,D,D,I repeating
        for (int i = 0; i < 10; i++) begin
            logic       win_i;
            logic [3:0] rt;
            win_i = (i % 5 == 4);
            rt    = 4'(i + 1);
            apply(mk(0, c_L, 64'h400 + 64'(i), c_L, 64'h800 + 64'(i), 64'h99, rt, 0, 0,
                     c_L, win_i ? 64'h400 + 64'(i) : 64'h800 + 64'(i), win_i ? 64'h0 : 64'h99,
                     win_i ? rt : 4'd0, win_i ? 4'd0 : rt, 0, 0, 0), "starve");
        end
        // Drain: tags 5 and 10 belong to Icache, the rest to Dcache
        for (int t = 1; t <= 10; t++) begin
            logic [3:0] tt;
            tt = 4'(t);
            apply(mk(0, c_N, 0, c_N, 0, 0, 0, tt, 64'(t) * 64'h1000, c_N, 0, 0, 0, 0,
                     (t == 5 || t == 10) ? tt : 4'd0, (t == 5 || t == 10) ? 4'd0 : tt, 0),
                  "drain");
        end

        // Allocating onto a live tag overwrites the owner and flags an error
        apply(mk(0, c_L, 64'h1C0, c_N, 0, 0, 9, 0, 0,       c_L, 64'h1C0, 0, 9, 0, 0, 0, 0), "clash");
        apply(mk(0, c_N, 0, c_L, 64'h2C0, 0, 9, 0, 0,       c_L, 64'h2C0, 0, 0, 9, 0, 0, 0), "clash");
        apply(mk(0, c_N, 0, c_N, 0, 0, 0, 9, 64'h9,         c_N, 0, 0, 0, 0, 0, 9, 1), "clash");
        // Reset drops an outstanding Icache tag; its late completion is an orphan
        apply(mk(0, c_L, 64'h1E0, c_N, 0, 0, 2, 0, 0,       c_L, 64'h1E0, 0, 2, 0, 0, 0, 1), "rstdrop");
        apply(mk(1, c_N, 0, c_N, 0, 0, 0, 0, 0,             c_N, 0, 0, 0, 0, 0, 0, 1), "rstdrop");
        apply(mk(0, c_N, 0, c_N, 0, 0, 0, 2, 64'hBEEF,      c_N, 0, 0, 0, 0, 0, 0, 0), "rstdrop");
        apply(mk(0, c_N, 0, c_N, 0, 0, 0, 0, 0,             c_N, 0, 0, 0, 0, 0, 0, 1), "rstdrop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
